overflow_tick_timer: RTL

//   Downstream consumer of the free-running counter's overflow flag.
//   - Counts overflow ticks and raises an interrupt every PERIOD ticks, so one

---
 rtl/overflow_tick_timer_pkg.sv | 19 +
 rtl/overflow_tick_timer_if.sv | 31 +++
 rtl/overflow_tick_timer_tick_edge_detect.sv | 24 ++
 rtl/overflow_tick_timer.sv | 118 +++++++++++
 4 files changed

// File: rtl/overflow_tick_timer_pkg.sv
// Shared types and helpers for the overflow tick timer.
// Holds the FSM state encoding, the default widths and the saturation limit helper.
package overflow_tick_pkg;

  localparam int EVT_W_DEF  = 8;
  localparam int MISS_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // All-ones value of a w-bit counter, used as the missed-event saturation point
  function automatic int miss_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/overflow_tick_timer_if.sv
// Control/status bundle between the tick timer and whatever drives it.
// The master side issues enable, ticks, period and the irq handshake.
// The slave side (the timer) returns irq, counters and busy.
interface overflow_tick_timer_if
  import overflow_tick_pkg::*;
#(
  parameter int EVT_W  = EVT_W_DEF,
  parameter int MISS_W = MISS_W_DEF
);

  logic              en;
  logic              tick_in;
  logic [EVT_W-1:0]  period;
  logic              irq_ack;
  logic              clr_missed;
  logic              irq;
  logic [EVT_W-1:0]  evt_count;
  logic [MISS_W-1:0] missed;
  logic              busy;

  modport master (
    output en, tick_in, period, irq_ack, clr_missed,
    input  irq, evt_count, missed, busy
  );

  modport slave (
    input  en, tick_in, period, irq_ack, clr_missed,
    output irq, evt_count, missed, busy
  );

endinterface

// File: rtl/overflow_tick_timer_tick_edge_detect.sv
// Rising-edge qualifier for the upstream overflow flag.
// A level held high for several cycles yields a single pulse, and the pulse is
// combinational from the input so no latency is added.
module tick_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic tick_q;

  // Remember last cycle's level so only the 0->1 transition qualifies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= in;
    end
  end

  assign pulse = in & ~tick_q;

endmodule

// File: rtl/overflow_tick_timer.sv
// Overflow tick timer: counts qualified overflow ticks from an upstream counter
// and raises irq every period_q ticks. irq is held until acknowledged; terminal
// events that land while irq is still pending are tallied in a saturating
// missed counter. period_q == 0 gives 2^EVT_W ticks per irq through wraparound.
module overflow_tick_timer
  import overflow_tick_pkg::*;
#(
  parameter int EVT_W  = EVT_W_DEF,
  parameter int MISS_W = MISS_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  overflow_tick_timer_if.slave  bus
);

  localparam logic [MISS_W-1:0] MISS_SAT = MISS_W'(miss_max(MISS_W));

  state_t            state, state_next;
  logic [EVT_W-1:0]  period_q, period_next;
  logic [EVT_W-1:0]  evt_count_q, evt_count_next;
  logic [MISS_W-1:0] missed_q, missed_next;
  logic              irq_q, irq_next;
  logic              miss_inc;
  logic              tick;
  logic              terminal;

  tick_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (bus.tick_in),
    .pulse (tick)
  );

  assign terminal = tick && (evt_count_q == period_q - EVT_W'(1));

  // Next-state and next-output decode; a terminal tick in PEND keeps irq high
  // and beats a simultaneous ack, and only counts as missed when not acked
  always_comb begin
    state_next     = state;
    period_next    = period_q;
    evt_count_next = evt_count_q;
    irq_next       = irq_q;
    miss_inc       = 1'b0;
    missed_next    = missed_q;

    if (!bus.en) begin
      state_next     = IDLE;
      evt_count_next = '0;
      irq_next       = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          evt_count_next = '0;
          period_next    = bus.period;
          state_next     = RUN;
        end
        RUN: begin
          if (terminal) begin
            evt_count_next = '0;
            irq_next       = 1'b1;
            state_next     = PEND;
          end else if (tick) begin
            evt_count_next = evt_count_q + 1'b1;
          end
        end
        PEND: begin
          if (terminal) begin
            evt_count_next = '0;
            irq_next       = 1'b1;
            miss_inc       = ~bus.irq_ack;
          end else begin
            if (tick) begin
              evt_count_next = evt_count_q + 1'b1;
            end
            if (bus.irq_ack) begin
              irq_next   = 1'b0;
              state_next = RUN;
            end
          end
        end
        default: begin
          state_next     = IDLE;
          evt_count_next = '0;
          irq_next       = 1'b0;
        end
      endcase
    end

    if (bus.clr_missed) begin
      missed_next = miss_inc ? MISS_W'(1) : '0;
    end else if (miss_inc && (missed_q != MISS_SAT)) begin
      missed_next = missed_q + 1'b1;
    end
  end

  // State and all visible outputs are registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      period_q    <= '0;
      evt_count_q <= '0;
      missed_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      state       <= state_next;
      period_q    <= period_next;
      evt_count_q <= evt_count_next;
      missed_q    <= missed_next;
      irq_q       <= irq_next;
    end
  end

  assign bus.irq       = irq_q;
  assign bus.evt_count = evt_count_q;
  assign bus.missed    = missed_q;
  assign bus.busy      = (state != IDLE);

endmodule
